// File: rtl/fun_fpusqr_altwb_pkg.sv
// Shared types and constants for the FP sqrt/div alternate writeback path.
// Holds the result entry layout, the FSM state encoding and the fop_* opcodes.
package fun_fpusqr_altwb_pkg;

  localparam int ALTWB_FU_PORT = 6;
  localparam int ALTWB_SIMD_W  = 68;

  localparam logic [12:0] fop_sqrtS  = 13'h0A0;
  localparam logic [12:0] fop_sqrtD  = 13'h0A1;
  localparam logic [12:0] fop_sqrtDH = 13'h0A2;
  localparam logic [12:0] fop_divS   = 13'h0B0;
  localparam logic [12:0] fop_divD   = 13'h0B1;
  localparam logic [12:0] fop_divDH  = 13'h0B2;

  // 'reg' is a keyword, so the destination register field is called rd.
  typedef struct packed {
    logic [3:0]                  en;
    logic [9:0]                  ii;
    logic [12:0]                 op;
    logic [8:0]                  rd;
    logic                        wen;
    logic [2*ALTWB_SIMD_W-1:0]   data;
  } altwb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PAUSE = 2'd2
  } altwb_state_e;

endpackage

// File: rtl/fun_fpusqr_altwb_fifo.sv
// Register-array FIFO holding completed sqrt/div results until a writeback slot opens.
// Callers only push when not at DEPTH and only pop when non-empty.
module fun_fpusqr_altwb_fifo
  import fun_fpusqr_altwb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  altwb_entry_t             wr_entry,
  output altwb_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  altwb_entry_t    mem [DEPTH];
  logic [PW-1:0]   head_ptr;
  logic [PW-1:0]   tail_ptr;

  // NOTE: the storage array has no reset; count gates every read, so stale
  // contents are never observed and the array stays plain flops without reset muxes.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[head_ptr];

endmodule

// File: rtl/fun_fpusqr_altwb.sv
// Buffers sqrt/div results and slips them onto the FU6 writeback port when the regular
// pipe leaves it free; raises pause to the scheduler once the head entry has starved.
module fun_fpusqr_altwb
  import fun_fpusqr_altwb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4,
  parameter int SIMD_WIDTH = ALTWB_SIMD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    except,
  input  logic [3:0]              sqr_en,
  input  logic [9:0]              sqr_II,
  input  logic [12:0]             sqr_op,
  input  logic [8:0]              sqr_reg,
  input  logic                    sqr_wen,
  input  logic [2*SIMD_WIDTH-1:0] sqr_data,
  input  logic                    slot_busy,
  output logic [3:0]              wb_en,
  output logic [9:0]              wb_II,
  output logic [12:0]             wb_op,
  output logic [8:0]              wb_reg,
  output logic                    wb_wen,
  output logic [SIMD_WIDTH-1:0]   wb_dataL,
  output logic [SIMD_WIDTH-1:0]   wb_dataH,
  output logic [3:0]              fxFRT_alten,
  output logic [3:0]              fxFRT_pause,
  output logic                    full,
  output logic                    ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_TH   = CW'(DEPTH - 1);
  localparam logic [SW-1:0] STARVE_C  = SW'(STARVE_MAX);

  altwb_entry_t   wr_entry;
  altwb_entry_t   head;
  altwb_entry_t   wb_q;
  logic [CW-1:0]  count;
  logic           at_depth;
  logic           push_req;
  logic           push_acc;
  logic           pop_fire;
  logic           entries_left;
  altwb_state_e   state_q, state_d;
  logic [SW-1:0]  starve_q, starve_d;

  assign wr_entry = '{en: sqr_en, ii: sqr_II, op: sqr_op, rd: sqr_reg,
                      wen: sqr_wen, data: sqr_data};

  assign push_req     = |sqr_en;
  assign at_depth     = (count == DEPTH_C);
  // A flush discards both a same-cycle push and a same-cycle pop.
  assign push_acc     = push_req && !at_depth && !except;
  assign pop_fire     = (count != '0) && !slot_busy && !except;
  assign entries_left = (count > CW'(1)) || push_acc;

  fun_fpusqr_altwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (except),
    .push     (push_acc),
    .pop      (pop_fire),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

  // NOTE: every variable is given a default before the case so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      ST_IDLE: begin
        if (push_acc) begin
          state_d  = ST_WAIT;
          starve_d = '0;
        end
      end
      ST_WAIT: begin
        if (pop_fire) begin
          starve_d = '0;
          state_d  = entries_left ? ST_WAIT : ST_IDLE;
        end else begin
          starve_d = starve_q + SW'(1);
          if (starve_d == STARVE_C) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        // A busy slot here is a scheduler protocol violation; hold until it frees.
        if (pop_fire) begin
          starve_d = '0;
          state_d  = entries_left ? ST_WAIT : ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        starve_d = '0;
      end
    endcase
    if (except) begin
      state_d  = ST_IDLE;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      wb_q     <= '0;
      ovf      <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (pop_fire) wb_q <= head;
      else          wb_q.en <= '0;
      if (push_req && at_depth && !except) ovf <= 1'b1;
    end
  end

  assign wb_en       = wb_q.en;
  assign wb_II       = wb_q.ii;
  assign wb_op       = wb_q.op;
  assign wb_reg      = wb_q.rd;
  assign wb_wen      = wb_q.wen;
  assign wb_dataL    = wb_q.data[SIMD_WIDTH-1:0];
  assign wb_dataH    = wb_q.data[2*SIMD_WIDTH-1:SIMD_WIDTH];
  assign fxFRT_alten = wb_q.en;
  assign fxFRT_pause = (state_q == ST_PAUSE) ? 4'hF : 4'h0;
  assign full        = (count >= FULL_TH);

endmodule

// File: tb/tb_fun_fpusqr_altwb.sv
// Directed self-checking bench for fun_fpusqr_altwb: reset, single pop, starvation/pause,
// back-to-back, overflow, flush and reset during a pop, with hand-derived expectations.
module tb_fun_fpusqr_altwb;
  import fun_fpusqr_altwb_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         except;
  logic [3:0]   sqr_en;
  logic [9:0]   sqr_II;
  logic [12:0]  sqr_op;
  logic [8:0]   sqr_reg;
  logic         sqr_wen;
  logic [135:0] sqr_data;
  logic         slot_busy;
  logic [3:0]   wb_en;
  logic [9:0]   wb_II;
  logic [12:0]  wb_op;
  logic [8:0]   wb_reg;
  logic         wb_wen;
  logic [67:0]  wb_dataL;
  logic [67:0]  wb_dataH;
  logic [3:0]   fxFRT_alten;
  logic [3:0]   fxFRT_pause;
  logic         full;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  fun_fpusqr_altwb dut (
    .clk         (clk),
    .rst         (rst),
    .except      (except),
    .sqr_en      (sqr_en),
    .sqr_II      (sqr_II),
    .sqr_op      (sqr_op),
    .sqr_reg     (sqr_reg),
    .sqr_wen     (sqr_wen),
    .sqr_data    (sqr_data),
    .slot_busy   (slot_busy),
    .wb_en       (wb_en),
    .wb_II       (wb_II),
    .wb_op       (wb_op),
    .wb_reg      (wb_reg),
    .wb_wen      (wb_wen),
    .wb_dataL    (wb_dataL),
    .wb_dataH    (wb_dataH),
    .fxFRT_alten (fxFRT_alten),
    .fxFRT_pause (fxFRT_pause),
    .full        (full),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [135:0] mk_data(input logic [9:0] ii);
    logic [63:0] hi_pat;
    logic [63:0] lo_pat;
    hi_pat = 64'hFEDC_BA98_7654_3210 ^ {54'd0, ii};
    lo_pat = 64'h0123_4567_89AB_CDEF + {54'd0, ii};
    return {4'h9, hi_pat, 4'h3, lo_pat};
  endfunction

  function automatic logic [8:0] mk_reg(input logic [9:0] ii);
    return ii[8:0] ^ 9'h1A5;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [9:0] ii, input logic [12:0] op);
    sqr_en   = en;
    sqr_II   = ii;
    sqr_op   = op;
    sqr_reg  = mk_reg(ii);
    sqr_wen  = ii[0];
    sqr_data = mk_data(ii);
  endtask

  task automatic no_push();
    sqr_en = 4'h0;
  endtask

  task automatic expect_wb(input string tag, input logic [3:0] en, input logic [9:0] ii);
    check({tag, "_en"},    wb_en, en);
    check({tag, "_alten"}, fxFRT_alten, en);
    check({tag, "_II"},    wb_II, ii);
  endtask

  initial begin
    logic [135:0] d;
    rst = 1'b0; except = 1'b0; slot_busy = 1'b0;
    sqr_en = '0; sqr_II = '0; sqr_op = '0; sqr_reg = '0; sqr_wen = 1'b0; sqr_data = '0;
    #1;
    check("rst_wb_en", wb_en, 4'h0);
    check("rst_alten", fxFRT_alten, 4'h0);
    check("rst_pause", fxFRT_pause, 4'h0);
    check("rst_full",  full, 1'b0);
    check("rst_ovf",   ovf, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);

    // Single result with a free slot: writeback two cycles after the push.
    drive(4'h3, 10'h05A, fop_sqrtDH);
    step(1);
    no_push();
    check("single_no_bypass", wb_en, 4'h0);
    step(1);
    d = mk_data(10'h05A);
    expect_wb("single", 4'h3, 10'h05A);
    check("single_op",    wb_op, fop_sqrtDH);
    check("single_reg",   wb_reg, mk_reg(10'h05A));
    check("single_wen",   wb_wen, 1'b0);
    check("single_dataL", wb_dataL, d[67:0]);
    check("single_dataH", wb_dataH, d[135:68]);
    step(1);
    check("single_one_cycle", wb_en, 4'h0);
    check("single_hold_II",   wb_II, 10'h05A);

    // Starvation: slot busy N..N+4, pause at N+5, pop at N+5, writeback at N+6.
    slot_busy = 1'b1;
    drive(4'hF, 10'h0B1, fop_divD);
    step(1);
    no_push();
    step(3);
    check("starve_pause_pre", fxFRT_pause, 4'h0);
    step(1);
    check("starve_pause", fxFRT_pause, 4'hF);
    slot_busy = 1'b0;
    step(1);
    expect_wb("starve", 4'hF, 10'h0B1);
    check("starve_pause_off", fxFRT_pause, 4'h0);
    step(1);

    // Slot stays busy while paused: no pop, entry kept until the slot frees.
    slot_busy = 1'b1;
    drive(4'h1, 10'h1C3, fop_sqrtS);
    step(1);
    no_push();
    step(6);
    check("viol_pause_held", fxFRT_pause, 4'hF);
    check("viol_no_pop",     wb_en, 4'h0);
    slot_busy = 1'b0;
    step(1);
    expect_wb("viol", 4'h1, 10'h1C3);
    check("viol_pause_off", fxFRT_pause, 4'h0);
    step(1);

    // Back-to-back pushes with a free slot drain in order.
    drive(4'h3, 10'h111, fop_divDH);
    step(1);
    check("b2b_full", full, 1'b1);
    drive(4'hC, 10'h222, fop_sqrtD);
    step(1);
    no_push();
    expect_wb("b2b_first", 4'h3, 10'h111);
    step(1);
    expect_wb("b2b_second", 4'hC, 10'h222);
    check("b2b_second_op", wb_op, fop_sqrtD);
    step(1);
    check("b2b_drained_en",   wb_en, 4'h0);
    check("b2b_drained_full", full, 1'b0);

    // Overflow: third push into a full two-entry buffer is dropped.
    slot_busy = 1'b1;
    drive(4'h1, 10'h301, fop_divS);
    step(1);
    drive(4'h2, 10'h302, fop_divS);
    step(1);
    drive(4'h4, 10'h303, fop_divS);
    step(1);
    no_push();
    check("ovf_set",  ovf, 1'b1);
    check("ovf_full", full, 1'b1);
    slot_busy = 1'b0;
    step(1);
    expect_wb("ovf_first", 4'h1, 10'h301);
    step(1);
    expect_wb("ovf_second", 4'h2, 10'h302);
    step(1);
    check("ovf_dropped_en", wb_en, 4'h0);
    check("ovf_dropped_II", wb_II, 10'h302);

    // Flush with two buffered entries and a simultaneous push and free slot.
    slot_busy = 1'b1;
    drive(4'h3, 10'h0F1, fop_sqrtD);
    step(1);
    drive(4'h3, 10'h0F2, fop_sqrtD);
    step(1);
    drive(4'h3, 10'h0F3, fop_sqrtD);
    except = 1'b1;
    slot_busy = 1'b0;
    step(1);
    except = 1'b0;
    no_push();
    check("flush_full",  full, 1'b0);
    check("flush_pause", fxFRT_pause, 4'h0);
    for (int i = 0; i < 4; i++) begin
      check("flush_no_wb", wb_en, 4'h0);
      step(1);
    end
    check("flush_ovf_kept", ovf, 1'b1);

    // Asynchronous reset while a writeback is on the port and an entry remains.
    drive(4'h5, 10'h2A1, fop_divD);
    step(1);
    drive(4'h6, 10'h2A2, fop_divD);
    step(1);
    no_push();
    expect_wb("prerst", 4'h5, 10'h2A1);
    rst = 1'b0;
    #1;
    check("midrst_wb_en", wb_en, 4'h0);
    check("midrst_alten", fxFRT_alten, 4'h0);
    check("midrst_II",    wb_II, 10'h000);
    check("midrst_dataL", wb_dataL, 68'h0);
    check("midrst_ovf",   ovf, 1'b0);
    check("midrst_full",  full, 1'b0);
    step(1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("postrst_no_wb", wb_en, 4'h0);
      check("postrst_full",  full, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
